fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Sequences all pixel writes into the single write port of the VGA framebuffer (x, y, pixel_color, pixel_write). It shares that port between two requesters: a full-screen clear and a square brush stamp at the cursor position. The block expands each request into a raster sequence of one pixel write per cycle, clips against the screen edges, and reports busy and done. It sits between the paint cursor/controller logic and the framebuffer.

## Interface

Parameters:
- WIDTH, default 640: screen width in pixels.
- HEIGHT, default 480: screen height in pixels.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous reset, active-low (asserted when 0).
- clear_req  in  1  request a full-screen clear; a one-cycle pulse is sufficient.
- clear_color  in  1  fill colour, sampled when the clear starts.
- stamp_req  in  1  request a brush stamp; sampled only in IDLE.
- cursor_x  in  10  stamp top-left x.
- cursor_y  in  9  stamp top-left y.
- stamp_color  in  1  brush colour, sampled with stamp_req.
- brush_size  in  4  square edge length; 0 is treated as 1.
- busy  out  1  high while in CLEAR or STAMP.
- done  out  1  one-cycle pulse after an operation completes.
- fb_x  out  10  framebuffer x.
- fb_y  out  9  framebuffer y.
- fb_color  out  1  framebuffer pixel colour.
- fb_write  out  1  framebuffer write enable.

## Operation

- States: IDLE, CLEAR, STAMP, DONE.
- clear_pend flag:
  - Set by clear_req in any state except CLEAR; clear_req during CLEAR is ignored.
  - Cleared on entry to CLEAR.
- IDLE:
  - If clear_pend or clear_req is set: go to CLEAR. Latch clear_color. Counters cx=0, cy=0.
  - Else if stamp_req: go to STAMP. Latch cursor_x, cursor_y, stamp_color, and size = max(brush_size,1). Counters dx=0, dy=0.
  - Clear takes priority when both requests arrive together; the stamp request is dropped.
- CLEAR:
  - Each cycle, write (cx, cy) with the latched colour.
  - cx increments and wraps from WIDTH-1 to 0; cy increments on each wrap.
  - After writing (WIDTH-1, HEIGHT-1), go to DONE.
- STAMP:
  - Each cycle, emit pixel (x0+dx, y0+dy) in raster order: dx is the inner loop, dy the outer loop.
  - Sums are computed 11 bits wide for x and 10 bits wide for y.
  - A pixel with x sum >= WIDTH or y sum >= HEIGHT is clipped: fb_write=0 for that cycle, but the cycle is still consumed.
  - After dx=dy=size-1, go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle; then IDLE.
  - A clear_pend set during STAMP starts a clear from the following IDLE cycle.
- stamp_req while not in IDLE is ignored. It is not queued.
- Reset while asserted:
  - State=IDLE; clear_pend=0.
  - All outputs 0: fb_x=0, fb_y=0, fb_color=0, fb_write=0, busy=0, done=0.
  - Reset mid-operation aborts it; no done pulse is generated.
- fb_color and fb_write are 0 in IDLE and DONE.

## Timing

- All outputs are registered.
- A request sampled at clk edge N (state IDLE) produces the first fb_write/coordinates valid after edge N+1. busy goes high at the same time.
- Throughput is one pixel per cycle, with no gaps.
- CLEAR occupies WIDTH*HEIGHT = 307200 cycles, then 1 DONE cycle.
- STAMP occupies size² cycles, then 1 DONE cycle. Clipping does not shorten it.
- Minimum request-to-request spacing: operation length + 2 cycles (DONE, IDLE).
- The framebuffer accepts a write every cycle. The block has no backpressure input.
- A cursor outside the screen (x>=640 or y>=480) yields a fully clipped stamp: zero writes, but done still pulses.

## Test plan

- Reset: hold reset=0 for 3 cycles with clear_req=1 -> all outputs 0 and no writes. Release reset -> no clear runs, because clear_pend was cleared.
- Stamp: size 3, colour 1, at (10,20).
  - Nine writes: (10,20),(11,20),(12,20),(10,21),…,(12,22).
  - fb_write=1 on 9 consecutive cycles; done pulses on the 10th cycle after busy rises.
- Clipping: stamp size 4 at (638,478) -> 16 busy cycles. Writes only at (638,478),(639,478),(638,479),(639,479); the other 12 cycles have fb_write=0.
- brush_size=0 at (5,5) -> exactly one write at (5,5); done pulses 2 cycles after the request edge.
- Arbitration: clear_req and stamp_req in the same IDLE cycle -> clear runs and the stamp is dropped. Then:
  - clear_req pulsed mid-stamp -> the stamp completes.
  - done pulses, and the clear's first write (0,0) follows on the second cycle after done.
- Full clear, colour 1 -> 307200 writes; first (0,0), (639,0)->(0,1) wrap, last (639,479); then done.
  - Repeat the clear with reset=0 asserted at write 1000 -> fb_write=0 after the next edge, with no done pulse.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Framebuffer write sequencer: expands full-screen clears and clipped square
// brush stamps into one registered pixel write per cycle on a single port.
module fb_write_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       clear_color,
  input  logic       stamp_req,
  input  logic [9:0] cursor_x,
  input  logic [8:0] cursor_y,
  input  logic       stamp_color,
  input  logic [3:0] brush_size,
  output logic       busy,
  output logic       done,
  output logic [9:0] fb_x,
  output logic [8:0] fb_y,
  output logic       fb_color,
  output logic       fb_write,
  output logic [1:0] state_dbg
);

  // Protocol: clear_req/stamp_req are single-cycle valids with no ready; a
  // request is taken only in IDLE (a clear is remembered in clear_pend
  // otherwise). fb_write is a valid with an always-ready sink, so every
  // registered fb_write=1 cycle is exactly one accepted pixel.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_STAMP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic        clear_pend;
  logic        color;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic [3:0]  size;
  logic [3:0]  dx;
  logic [3:0]  dy;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;
  logic        clip;
  logic        clear_last;
  logic        stamp_last;
  logic        start_clear;

  assign state_dbg   = state;
  // One bit of headroom so a stamp hanging off the edge never aliases on-screen.
  assign sum_x       = {1'b0, x0} + {7'd0, dx};
  assign sum_y       = {1'b0, y0} + {6'd0, dy};
  assign clip        = (sum_x >= 11'(WIDTH)) || (sum_y >= 10'(HEIGHT));
  assign clear_last  = (cx == 10'(WIDTH - 1)) && (cy == 9'(HEIGHT - 1));
  assign stamp_last  = (dx == size - 4'd1) && (dy == size - 4'd1);
  assign start_clear = (state == S_IDLE) && (clear_pend || clear_req);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      clear_pend <= 1'b0;
      color      <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      x0         <= '0;
      y0         <= '0;
      size       <= 4'd1;
      dx         <= '0;
      dy         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fb_x       <= '0;
      fb_y       <= '0;
      fb_color   <= 1'b0;
      fb_write   <= 1'b0;
    end else begin
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_write <= 1'b0;
      fb_color <= 1'b0;

      if (start_clear)
        clear_pend <= 1'b0;
      else if (state != S_CLEAR && clear_req)
        clear_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_clear) begin
            state <= S_CLEAR;
            color <= clear_color;
            cx    <= '0;
            cy    <= '0;
          end else if (stamp_req) begin
            state <= S_STAMP;
            color <= stamp_color;
            x0    <= cursor_x;
            y0    <= cursor_y;
            size  <= (brush_size == 4'd0) ? 4'd1 : brush_size;
            dx    <= '0;
            dy    <= '0;
          end
        end
        S_CLEAR: begin
          busy     <= 1'b1;
          fb_write <= 1'b1;
          fb_color <= color;
          fb_x     <= cx;
          fb_y     <= cy;
          if (cx == 10'(WIDTH - 1)) begin
            cx <= '0;
            cy <= cy + 9'd1;
          end else begin
            cx <= cx + 10'd1;
          end
          if (clear_last)
            state <= S_DONE;
        end
        S_STAMP: begin
          // Clipped pixels still burn their cycle so stamp length is size^2.
          busy     <= 1'b1;
          fb_write <= !clip;
          fb_color <= color;
          fb_x     <= sum_x[9:0];
          fb_y     <= sum_y[8:0];
          if (dx == size - 4'd1) begin
            dx <= '0;
            dy <= dy + 4'd1;
          end else begin
            dx <= dx + 4'd1;
          end
          if (stamp_last)
            state <= S_DONE;
        end
        default: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: pixel-index reference model checked every
// cycle, plus directed literal checks for stamps, clipping, arbitration, reset.
module tb_fb_write_scheduler;

  localparam int W = 640;
  localparam int H = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_req = 1'b0;
  logic       clear_color = 1'b0;
  logic       stamp_req = 1'b0;
  logic [9:0] cursor_x = '0;
  logic [8:0] cursor_y = '0;
  logic       stamp_color = 1'b0;
  logic [3:0] brush_size = '0;
  logic       busy, done, fb_color, fb_write;
  logic [9:0] fb_x;
  logic [8:0] fb_y;
  logic [1:0] state_dbg;

  fb_write_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_color(clear_color),
    .stamp_req(stamp_req), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .stamp_color(stamp_color), .brush_size(brush_size), .busy(busy), .done(done),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish within 90000 cycles");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int xy(input int x, input int y);
    return x * 512 + y;
  endfunction

  // Reference model: an operation is a list of m_len pixels indexed by m_k.
  int m_phase = 0;  // 0 idle, 1 clearing, 2 stamping, 3 finishing
  int m_k, m_len, m_x0, m_y0, m_sz, px, py;
  bit m_col, m_pend;
  bit e_busy, e_done, e_write, e_color, e_xy_chk, e_col_chk;
  int e_x, e_y;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_phase = 0; m_pend = 0;
      e_busy = 0; e_done = 0; e_write = 0; e_color = 0;
      e_x = 0; e_y = 0; e_xy_chk = 1; e_col_chk = 1;
    end else begin
      e_busy = 0; e_done = 0; e_write = 0; e_color = 0; e_xy_chk = 0; e_col_chk = 1;
      if (m_phase == 1) begin
        e_busy = 1; e_write = 1; e_color = m_col;
        e_x = m_k % W; e_y = m_k / W; e_xy_chk = 1;
      end else if (m_phase == 2) begin
        px = m_x0 + m_k % m_sz;
        py = m_y0 + m_k / m_sz;
        e_busy = 1; e_write = (px < W) && (py < H); e_color = m_col;
        e_x = px; e_y = py; e_xy_chk = e_write; e_col_chk = e_write;
      end else if (m_phase == 3) begin
        e_done = 1;
      end
      if (m_phase != 1 && clear_req) m_pend = 1;
      case (m_phase)
        0: begin
          if (m_pend) begin
            m_phase = 1; m_k = 0; m_len = W * H; m_col = clear_color; m_pend = 0;
          end else if (stamp_req) begin
            m_phase = 2; m_k = 0;
            m_x0 = int'(cursor_x); m_y0 = int'(cursor_y);
            m_sz = (brush_size == 0) ? 1 : int'(brush_size);
            m_len = m_sz * m_sz; m_col = stamp_color;
          end
        end
        1, 2: begin
          m_k++;
          if (m_k == m_len) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("fb_write", int'(fb_write), int'(e_write));
    if (e_col_chk) chk("fb_color", int'(fb_color), int'(e_color));
    if (e_xy_chk) begin
      chk("fb_x", int'(fb_x), e_x);
      chk("fb_y", int'(fb_y), e_y);
    end
  end

  // scoreboard of observed writes and timing marks
  logic [18:0] wq[$];
  int busy_cnt, first_busy, first_wr, done_cyc, n_done, req_edge;

  always @(negedge clk) begin
    if (fb_write) begin
      if (first_wr < 0) first_wr = cyc;
      wq.push_back({fb_x, fb_y});
    end
    if (busy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic reset_marks();
    wq.delete();
    busy_cnt = 0; first_busy = -1; first_wr = -1; done_cyc = -1; n_done = 0;
  endtask

  task automatic request(input bit clr, input bit clr_col, input bit stp,
                         input int x, input int y, input int sz, input bit col);
    @(negedge clk); #1;
    reset_marks();
    clear_req = clr; clear_color = clr_col; stamp_req = stp;
    cursor_x = 10'(x); cursor_y = 9'(y); brush_size = 4'(sz); stamp_color = col;
    req_edge = cyc + 1;
    @(negedge clk); #1;
    clear_req = 0; stamp_req = 0;
  endtask

  task automatic raw_pulse(input bit clr, input bit clr_col, input bit stp);
    @(negedge clk); #1;
    clear_req = clr; clear_color = clr_col; stamp_req = stp;
    cursor_x = 10'($urandom_range(0, 639)); cursor_y = 9'($urandom_range(0, 23));
    brush_size = 4'($urandom_range(0, 15));
    @(negedge clk); #1;
    clear_req = 0; stamp_req = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (n_done == 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk(name, n_done, 1);
  endtask

  function automatic int span(input int p, input int s, input int lim);
    if (p >= lim) return 0;
    return (p + s > lim) ? lim - p : s;
  endfunction

  int ex3_x[9] = '{10, 11, 12, 10, 11, 12, 10, 11, 12};
  int ex3_y[9] = '{20, 20, 20, 21, 21, 21, 22, 22, 22};
  int exc_x[4] = '{638, 639, 638, 639};
  int exc_y[4] = '{22, 22, 23, 23};

  initial begin
    int x, y, s, sel, d;
    reset_marks();
    // reset held with clear_req high
    clear_req = 1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_write", int'(fb_write), 0);
      chk("rst_xy", int'({fb_x, fb_y}), 0);
      chk("rst_color", int'(fb_color), 0);
      chk("rst_state", int'(state_dbg), 0);
    end
    reset = 1; clear_req = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_no_clear_busy", int'(busy), 0);
    chk("post_rst_no_writes", wq.size(), 0);

    // 3x3 stamp
    request(0, 0, 1, 10, 20, 3, 1);
    wait_done("stamp3_done", 40);
    chk("stamp3_count", wq.size(), 9);
    for (int i = 0; i < 9; i++)
      chk("stamp3_px", (i < wq.size()) ? int'(wq[i]) : -1, xy(ex3_x[i], ex3_y[i]));
    chk("stamp3_busy_rise", first_busy - req_edge, 1);
    chk("stamp3_done_lat", done_cyc - req_edge, 10);
    chk("stamp3_busy_cycles", busy_cnt, 9);

    // clipped corner stamp
    request(0, 0, 1, 638, 22, 4, 0);
    wait_done("clip_done", 40);
    chk("clip_count", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("clip_px", (i < wq.size()) ? int'(wq[i]) : -1, xy(exc_x[i], exc_y[i]));
    chk("clip_busy_cycles", busy_cnt, 16);

    // size 0 acts as size 1
    request(0, 0, 1, 5, 5, 0, 1);
    wait_done("sz0_done", 20);
    chk("sz0_count", wq.size(), 1);
    chk("sz0_px", (wq.size() > 0) ? int'(wq[0]) : -1, xy(5, 5));
    chk("sz0_done_lat", done_cyc - req_edge, 2);

    // cursors off-screen
    request(0, 0, 1, 700, 3, 2, 1);
    wait_done("offx_done", 20);
    chk("offx_count", wq.size(), 0);
    chk("offx_busy_cycles", busy_cnt, 4);
    request(0, 0, 1, 3, 30, 2, 1);
    wait_done("offy_done", 20);
    chk("offy_count", wq.size(), 0);

    // clear wins over a simultaneous stamp; requests during clear are ignored
    request(1, 0, 1, 50, 5, 3, 1);
    repeat (20) @(negedge clk);
    raw_pulse(1, 1, 1);
    wait_done("arb_clear_done", W * H + 50);
    chk("arb_clear_count", wq.size(), W * H);
    chk("arb_done_lat", done_cyc - req_edge, W * H + 1);
    repeat (4) @(negedge clk);
    #1;
    chk("arb_no_requeue_busy", int'(busy), 0);
    chk("arb_no_requeue_writes", wq.size(), W * H);

    // clear requested mid-stamp runs after the stamp
    request(0, 0, 1, 100, 10, 5, 1);
    repeat (10) @(negedge clk);
    raw_pulse(1, 1, 0);
    wait_done("midstamp_done", 40);
    chk("midstamp_count", wq.size(), 25);
    d = done_cyc;
    reset_marks();
    wait_done("clear1_done", W * H + 50);
    chk("clear1_first_gap", first_wr - d, 2);
    chk("clear1_count", wq.size(), W * H);
    if (wq.size() == W * H) begin
      chk("clear1_first", int'(wq[0]), xy(0, 0));
      chk("clear1_row_end", int'(wq[W - 1]), xy(W - 1, 0));
      chk("clear1_wrap", int'(wq[W]), xy(0, 1));
      chk("clear1_last", int'(wq[W * H - 1]), xy(W - 1, H - 1));
    end

    // clear aborted by reset after 1000 writes
    request(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000 && wq.size() < 1000; i++) begin
      @(negedge clk); #1;
    end
    reset = 0;
    @(negedge clk); #1;
    chk("abort_write", int'(fb_write), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", wq.size(), 1000);
    repeat (2) @(negedge clk);
    #1;
    reset = 1;
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", int'(busy), 0);

    // randomized stamps with ignored stamp_req noise
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 3);
      x = (sel == 0) ? $urandom_range(0, 639) : (sel == 1) ? $urandom_range(625, 639) :
          (sel == 2) ? $urandom_range(640, 1023) : $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      y = (sel == 0) ? $urandom_range(0, 23) : (sel == 1) ? $urandom_range(15, 23) :
          (sel == 2) ? $urandom_range(24, 511) : $urandom_range(0, 3);
      s = $urandom_range(0, 15);
      request(0, 0, 1, x, y, s, 1'($urandom_range(0, 1)));
      if (s >= 2) raw_pulse(0, 0, 1);
      wait_done("rnd_done", 300);
      if (s == 0) s = 1;
      chk("rnd_count", wq.size(), span(x, s, W) * span(y, s, H));
      chk("rnd_busy_cycles", busy_cnt, s * s);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
